// File: rtl/pipe_fetch_queue.sv
// Fetch stage with a DEPTH-entry circular queue of {pc4, inst} feeding ID.
// Optional macro PIPE_FETCH_QUEUE_BYPASS_EN adds a zero-latency empty-queue bypass.
module pipe_fetch_queue #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [IMEM_AW-1:0]       imem_addr,
  input  logic [WIDTH-1:0]         imem_data,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [WIDTH-1:0]         id_inst,
  output logic [31:0]              id_pc4,
  output logic [31:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] inst_q [DEPTH];
  logic [31:0]      pc4_q  [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4;
  logic             full;
  logic             stored_valid;
  logic             pop;
  logic             push;
  logic             advance;

  assign pc_plus4     = pc_q + 32'd4;
  assign full         = (count_q == CW'(DEPTH));
  assign stored_valid = (count_q != '0);
  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign fetch_pc     = pc_q;
  assign count        = count_q;

  // Handshake decode; redirect suppresses both sides of the queue.
  always_comb begin
    pop      = stored_valid & id_ready & ~redirect;
    push     = 1'b0;
    advance  = 1'b0;
    id_valid = stored_valid;
    id_inst  = inst_q[rd_ptr];
    id_pc4   = pc4_q[rd_ptr];
`ifdef PIPE_FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the memory word straight to ID; a taken
    // bypass advances fetch without ever occupying a slot.
    if (!stored_valid && !redirect) begin
      id_valid = 1'b1;
      id_inst  = imem_data;
      id_pc4   = pc_plus4;
      if (id_ready) begin
        advance = 1'b1;
      end else begin
        push    = 1'b1;
        advance = 1'b1;
      end
    end else begin
      push    = ~redirect & (~full | pop);
      advance = push;
    end
`else
    push    = ~redirect & (~full | pop);
    advance = push;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc4_q[i]  <= '0;
      end
    end else if (redirect) begin
      pc_q    <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        inst_q[wr_ptr] <= imem_data;
        pc4_q[wr_ptr]  <= pc_plus4;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (advance) begin
        pc_q <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Scoreboard bench for pipe_fetch_queue: a reference queue tracks fetched
// {pc4, inst} pairs and is compared against the ID head on every cycle.
module tb_pipe_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic [31:0] fetch_pc;
  logic [2:0]  count;

  logic [31:0] mem [1024];
  entry_t      sb [$];
  logic [31:0] mpc;
  int          assertions;
  int          failures;

  pipe_fetch_queue #(
    .WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .IMEM_AW(10)
  ) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .id_ready(id_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc4(id_pc4),
    .fetch_pc(fetch_pc), .count(count)
  );

  assign imem_data = mem[imem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: checks the ID head against the scoreboard before the
  // edge, advances the reference model, then checks fetch state after it.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    logic   popped;
    logic   taken;
    logic   was_full;
    entry_t e;
    reset       = rst;
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    popped = 1'b0;
    taken  = 1'b0;
    if (rst) begin
      sb.delete();
      mpc = 32'h0000_0000;
    end else begin
`ifdef PIPE_FETCH_QUEUE_BYPASS_EN
      if (sb.size() == 0 && !redir) begin
        checkOutput("bypass_valid", 32'(id_valid), 32'd1);
        checkOutput("bypass_inst", id_inst, mem[mpc[11:2]]);
        checkOutput("bypass_pc4", id_pc4, mpc + 32'd4);
        if (rdy) begin
          taken = 1'b1;
          mpc   = mpc + 32'd4;
        end
      end else begin
        checkOutput("id_valid", 32'(id_valid), 32'(sb.size() != 0));
      end
`else
      checkOutput("id_valid", 32'(id_valid), 32'(sb.size() != 0));
`endif
      if (sb.size() != 0) begin
        checkOutput("head_inst", id_inst, sb[0].inst);
        checkOutput("head_pc4", id_pc4, sb[0].pc4);
      end
      if (redir) begin
        sb.delete();
        mpc = rpc & 32'hFFFF_FFFC;
      end else if (!taken) begin
        was_full = (sb.size() >= DEPTH);
        popped   = (sb.size() != 0) && rdy;
        if (popped) void'(sb.pop_front());
        if (!was_full || popped) begin
          e.inst = mem[mpc[11:2]];
          e.pc4  = mpc + 32'd4;
          sb.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
    @(posedge clock);
    #1;
    checkOutput("fetch_pc", fetch_pc, mpc);
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("imem_addr", 32'(imem_addr), 32'(mpc[11:2]));
  endtask

  initial begin
    assertions  = 0;
    failures    = 0;
    mpc         = 32'h0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);

    $display("[TB] reset together with redirect");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    checkOutput("reset_fetch_pc", fetch_pc, 32'h0);
    checkOutput("reset_valid", 32'(id_valid), 32'h0);
    checkOutput("reset_inst", id_inst, 32'h0);
    checkOutput("reset_pc4", id_pc4, 32'h0);

    $display("[TB] fill with ID stalled");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_fetch_pc", fetch_pc, 32'h10);
    checkOutput("full_head_inst", id_inst, 32'h1000_0000);
    checkOutput("full_head_pc4", id_pc4, 32'h4);

    $display("[TB] streaming from full");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("stream_fetch_pc", fetch_pc, 32'h30);

    $display("[TB] redirect while full");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    checkOutput("redir_fetch_pc", fetch_pc, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_inst", id_inst, 32'h1000_0040);
    checkOutput("redir_pc4", id_pc4, 32'h104);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    $display("[TB] PC wrap at top of address space");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_imem_addr", 32'(imem_addr), 32'h3FE);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    $display("[TB] reset mid-stream, then resume");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    checkOutput("midreset_inst", id_inst, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_queue.md
Name: pipe_fetch_queue

Overview:
Parametrised successor to the single-entry instruction register between IF and ID in the 5-stage pipelined CPU. Owns the fetch PC, reads instruction memory each cycle and buffers up to DEPTH {pc4, inst} pairs in a circular FIFO. Decouples fetch from ID stalls. Flushes and re-targets on branch/jump redirect from ID.

Parameters:
WIDTH, 32, instruction word width in bits
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset; word aligned
IMEM_AW, 10, instruction memory word-address width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
redirect  in  1  branch/jump taken in ID; flush queue and re-target fetch
redirect_pc  in  32  new fetch PC, valid when redirect=1
imem_addr  out  IMEM_AW  word address to instruction memory, = fetch_pc[IMEM_AW+1:2]
imem_data  in  WIDTH  instruction memory read data, combinational from imem_addr
id_ready  in  1  ID accepts the head entry this cycle (0 = stall)
id_valid  out  1  head entry valid
id_inst  out  WIDTH  head instruction
id_pc4  out  32  head instruction address + 4
fetch_pc  out  32  current fetch PC
count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Reset (synchronous, active-high; overrides everything, including redirect): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, id_valid=0, id_inst=0, id_pc4=0. All storage entries cleared to 0.
- pop = id_valid & id_ready & ~redirect.
- push = ~redirect & (count<DEPTH | pop). Push writes {fetch_pc+4, imem_data} at wr_ptr.
- fetch_pc <= fetch_pc+4 on push; otherwise holds. 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000; pc4 of that entry = 0.
- count <= count + push - pop. Push and pop in the same cycle at full or partial occupancy: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; no extra wrap bit; full/empty derived from count.
- id_valid = (count != 0). id_inst and id_pc4 come from storage at rd_ptr. No combinational path from imem_data to ID outputs.
- Latency: instruction at fetch_pc appears on id_inst one cycle after the push edge. Steady state with id_ready=1: one instruction per cycle.
- Redirect (priority over push and pop):
  - next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - No push and no pop occur that cycle. imem_data is discarded.
  - id_valid=0 for the cycle after redirect. The first new instruction is visible the cycle after that.
- Full with id_ready=0: no push, fetch_pc and imem_addr hold, contents unchanged.
- Empty: id_valid=0, id_ready ignored. id_inst and id_pc4 show the stale rd_ptr entry.
- Reset asserted mid-stream or together with redirect: reset values win, and redirect_pc is ignored.

Optional Feature:
PIPE_FETCH_QUEUE_BYPASS_EN
- Defined:
  - When count==0 and no redirect, id_valid=1 and id_inst=imem_data, id_pc4=fetch_pc+4 combinationally.
  - If id_ready=1, the entry is consumed without being written (no push, fetch_pc+=4, count stays 0).
  - If id_ready=0, it is pushed normally.
  - Empty-queue latency becomes 0 cycles, matching the legacy IF/ID timing.
- Undefined: behaviour exactly as above; 1-cycle minimum latency, ID outputs purely registered.

Test Plan:
- Reset with redirect=1, redirect_pc=0x200 -> next cycle fetch_pc=0x0, count=0, id_valid=0, id_inst=0, id_pc4=0.
- DEPTH=4, mem[i]=0x1000_0000+i, id_ready=0 for 6 cycles -> count=4 after 4 edges, fetch_pc=0x10 and held. id_inst=0x1000_0000, id_pc4=0x4.
- From full, id_ready=1 for 8 cycles -> one pop+push per cycle, count stays 4. id_pc4 sequence 0x4,0x8,...,0x20, then fetch_pc=0x30.
- Full queue, redirect=1, redirect_pc=0x103 -> next cycle count=0, id_valid=0, fetch_pc=0x100. Following cycle id_inst=mem[0x40], id_pc4=0x104.
- redirect_pc=0xFFFF_FFF8, id_ready=1 -> pc4 sequence 0xFFFF_FFFC, 0x0, 0x4. imem_addr wraps to 0 correctly.
- Bypass macro defined, empty queue, id_ready=1 -> id_inst=imem_data in the same cycle, count stays 0. Undefined: first id_valid one cycle later.
